// File: rtl/mac_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// mac_accumulator_pkg
// Shared DSP definitions for the MAC accumulate stage:
//   - state_t     : accumulator FSM states (ACCUM collects beats, HOLD
//                   presents a finished frame)
//   - acc_width() : accumulator width that can hold a full-scale frame
//   - len_legal() : frame-length legality predicate used at elaboration
// No ports (package).
// ---------------------------------------------------------------------------
package mac_accumulator_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 256;

  // Sum of len products of 2n bits each needs clog2(len) extra bits.
  function automatic int acc_width(input int n, input int len);
    return 2 * n + $clog2(len);
  endfunction

  function automatic bit len_legal(input int len);
    return (len >= LEN_MIN) && (len <= LEN_MAX);
  endfunction

endpackage

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
// Accumulates LEN unsigned 2N-bit products (one per in_valid/in_ready
// handshake) into a single frame sum and presents it on a valid/ready port.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous frame abort, highest priority
//   in_valid   in   in_product valid
//   in_ready   out  block accepts a product (high only in ACCUM)
//   in_product in   2N-bit unsigned product
//   out_valid  out  out_sum holds a completed frame
//   out_ready  in   downstream accepts out_sum
//   out_sum    out  ACC_W-bit frame sum
//   frame_cnt  out  products accepted in the current frame
// ---------------------------------------------------------------------------
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int N     = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = acc_width(N, LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*N-1:0]          in_product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic [$clog2(LEN)-1:0]  frame_cnt
);

  localparam int CNT_W = $clog2(LEN);

  // Reject illegal configurations while elaborating.
  generate
    if (!len_legal(LEN)) begin : g_bad_len
      $error("mac_accumulator: LEN=%0d outside 2..256", LEN);
    end
    if (ACC_W < acc_width(N, LEN)) begin : g_bad_acc_w
      $error("mac_accumulator: ACC_W=%0d too narrow for N=%0d LEN=%0d", ACC_W, N, LEN);
    end
  endgenerate

  state_t             state_r;
  state_t             next_state_s;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   out_sum_r;
  logic               out_valid_r;
  logic               in_ready_s;
  logic               accept_s;
  logic               last_s;
  logic [ACC_W-1:0]   sum_s;

  assign accept_s = in_valid && in_ready_s;
  assign last_s   = (cnt_r == CNT_W'(LEN - 1));
  assign sum_s    = acc_r + {{(ACC_W - 2 * N){1'b0}}, in_product};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; clear always returns to ACCUM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (clear) begin
          next_state_s = ACCUM;
        end else if (accept_s && last_s) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = ACCUM;
        end
      end
      HOLD: begin
        if (clear || out_ready) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = ACCUM;
    endcase
  end

  // FSM outputs: in_ready depends on state only, never on in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ACCUM:   in_ready_s = 1'b1;
      HOLD:    in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Datapath: accumulator, beat counter and the registered result port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_sum_r   <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (clear) begin
      // A beat arriving with clear is consumed but not summed.
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            if (last_s) begin
              out_sum_r   <= sum_s;
              out_valid_r <= 1'b1;
              acc_r       <= {ACC_W{1'b0}};
              cnt_r       <= {CNT_W{1'b0}};
            end else begin
              acc_r <= sum_s;
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // out_sum keeps its value after the handshake.
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign frame_cnt = cnt_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
// Randomised scoreboard bench for mac_accumulator (N=4, LEN=8, ACC_W=11).
// A frame-level reference model pushes each expected frame sum into a
// queue; an independent monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

  localparam int N     = 4;
  localparam int LEN   = 8;
  localparam int ACC_W = 11;
  localparam int CW    = 3;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    frame_cnt;

  mac_accumulator #(.N(N), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running sum and beat count of the open frame, and
  // whether a finished frame is waiting for the consumer.
  int m_sum  = 0;
  int m_cnt  = 0;
  bit m_hold = 1'b0;
  int exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must deliver the oldest expected sum.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", longint'(out_sum), -1);
      end else begin
        check("scoreboard_sum", longint'(out_sum), longint'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; compares status outputs against the model, then
  // advances the model by the handshake rules.
  task automatic step(input bit v, input int p, input bit ordy, input bit clr);
    in_valid   = v;
    in_product = p[2*N-1:0];
    out_ready  = ordy;
    clear      = clr;
    @(negedge clk);
    check("in_ready",  longint'(in_ready),  longint'(!m_hold));
    check("out_valid", longint'(out_valid), longint'(m_hold));
    check("frame_cnt", longint'(frame_cnt), longint'(m_cnt));
    if (m_hold && exp_q.size() > 0) check("hold_stable", longint'(out_sum), longint'(exp_q[0]));
    if (clr) begin
      if (m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
      m_hold = 1'b0;
      m_sum  = 0;
      m_cnt  = 0;
    end else if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (v) begin
      m_sum += p;
      m_cnt++;
      if (m_cnt == LEN) begin
        exp_q.push_back(m_sum);
        m_sum  = 0;
        m_cnt  = 0;
        m_hold = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse away from the clock edge; outputs must clear at once.
  task automatic pulse_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_frame_cnt", longint'(frame_cnt), 0);
    check("rst_in_ready",  longint'(in_ready),  1);
    m_sum = 0; m_cnt = 0; m_hold = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready",  longint'(in_ready),  1);
    check("post_rst_out_valid", longint'(out_valid), 0);
    check("post_rst_frame_cnt", longint'(frame_cnt), 0);
  endtask

  task automatic random_frame();
    for (int i = 0; i < LEN; i++) step(1'b1, $urandom_range(0, 225), 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
    #12;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_sum",   longint'(out_sum),   0);
    check("reset_frame_cnt", longint'(frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", longint'(in_ready), 1);

    // Full-scale back-to-back frame.
    for (int i = 0; i < LEN; i++) step(1'b1, 225, 1'b1, 1'b0);
    check("fullscale_valid", longint'(out_valid), 1);
    check("fullscale_sum",   longint'(out_sum),   1800);
    step(1'b1, 7, 1'b1, 1'b0);   // bubble: offered beat is not accepted
    step(1'b0, 0, 1'b1, 1'b0);

    // Beats 1..8 with a stalled consumer.
    for (int i = 1; i <= LEN; i++) step(1'b1, i, 1'b0, 1'b0);
    check("stall_sum", longint'(out_sum), 36);
    for (int i = 0; i < 5; i++) step(1'b1, 99, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Random input gaps, long gaps before beats 3 and 6.
    for (int i = 1; i <= LEN; i++) begin
      int gap;
      gap = (i == 3 || i == 6) ? 4 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step(1'b0, $urandom_range(0, 255), 1'b1, 1'b0);
      step(1'b1, $urandom_range(0, 225), 1'b1, 1'b0);
    end
    step(1'b0, 0, 1'b1, 1'b0);

    // Abort after 5 beats; the beat coincident with clear is dropped.
    for (int i = 0; i < 5; i++) step(1'b1, 10, 1'b1, 1'b0);
    step(1'b1, 10, 1'b1, 1'b1);
    for (int i = 0; i < LEN; i++) step(1'b1, 1, 1'b1, 1'b0);
    check("clear_sum", longint'(out_sum), 8);
    step(1'b0, 0, 1'b1, 1'b0);

    // Clear while a result is pending drops it.
    for (int i = 0; i < LEN; i++) step(1'b1, 50, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    random_frame();

    // Reset mid-frame (cnt=3) and during HOLD.
    for (int i = 0; i < 3; i++) step(1'b1, 100, 1'b1, 1'b0);
    pulse_reset();
    random_frame();
    for (int i = 0; i < LEN; i++) step(1'b1, 200, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    pulse_reset();
    random_frame();

    // All-zero frame still completes.
    for (int i = 0; i < LEN; i++) step(1'b1, 0, 1'b1, 1'b0);
    check("zero_valid", longint'(out_valid), 1);
    check("zero_sum",   longint'(out_sum),   0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Random soak with occasional clears and consumer stalls.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 225),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end

    // Drain any pending result within a bounded number of cycles.
    for (int i = 0; i < 4 && (exp_q.size() != 0 || m_hold); i++) step(1'b0, 0, 1'b1, 1'b0);
    check("drain_queue_empty", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
